// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types, widths and address-decode helper for the APB completer
// (apb_slave_mem) and its register bank.
// -----------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_slv_state_t;

    // Flags a word access that is misaligned or falls outside the DEPTH-word
    // window starting at base. The subtraction is unsigned, so addresses
    // below base wrap to large offsets and land out of range.
    function automatic logic apb_addr_err(
        input logic [APB_ADDR_W-1:0] addr,
        input logic [APB_ADDR_W-1:0] base,
        input int unsigned           depth
    );
        logic [APB_ADDR_W-1:0] off;
        off = addr - base;
        return (addr[1:0] != 2'b00) || (off >= APB_ADDR_W'(depth << 2));
    endfunction

endpackage

// File: rtl/apb_regbank.sv
// -----------------------------------------------------------------------------
// apb_regbank
// DEPTH x DATA_WIDTH flop array, cleared by async reset.
// Ports:
//   pclk, preset_n   clock / async active-low clear of every word
//   i_we             write enable (word i_widx <= i_wdata at pclk rise)
//   i_widx, i_wdata  write port
//   i_ridx, o_rdata  combinational read port
// -----------------------------------------------------------------------------
module apb_regbank #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     pclk,
    input  logic                     preset_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_widx,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_ridx,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_mem <= '0;
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
// APB completer backed by a word-addressed register bank, with WAIT_CYCLES
// wait states before pready and pslverr on misaligned / out-of-range access.
// Ports:
//   pclk, preset_n           clock / async active-low reset
//   psel, penable, pwrite    APB control from the requester
//   paddr, pwdata            byte address / write data (latched at setup)
//   prdata, pready, pslverr  response; prdata and pslverr are 0 unless pready
// -----------------------------------------------------------------------------
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 64,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = $clog2(DEPTH);

    apb_slv_state_t        r_state, w_state_nxt, w_phase;
    logic [3:0]            r_wcnt, w_wcnt_nxt;
    logic                  r_write, r_err;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_latch, w_err, w_ready, w_we;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_off = paddr - BASE_ADDR;
    assign w_idx = IDX_W'(w_off >> 2);
    assign w_err = apb_addr_err(APB_ADDR_W'(paddr), APB_ADDR_W'(BASE_ADDR), DEPTH);

    // The setup phase is the cycle in which psel rises with penable low; it
    // is recognised combinationally so the registered state is already
    // ACCESS in the first penable cycle (zero-wait pready needs this).
    // psel+penable seen outside ACCESS is not a setup and is ignored.
    always_comb begin
        w_phase = IDLE;
        if (r_state == ACCESS) begin
            w_phase = ACCESS;
        end else if (psel && !penable) begin
            w_phase = SETUP;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_latch     = 1'b0;
        case (w_phase)
            SETUP: begin
                w_latch     = 1'b1;
                w_wcnt_nxt  = 4'(WAIT_CYCLES);
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!psel) begin
                    w_state_nxt = IDLE;              // abort: no write
                end else if (penable) begin
                    if (r_wcnt != 4'd0) begin
                        w_wcnt_nxt = r_wcnt - 4'd1;
                    end else begin
                        w_state_nxt = IDLE;          // completion cycle
                    end
                end
                // psel with penable low: requester is stalling, hold count
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (w_latch) begin
                r_write <= pwrite;
                r_err   <= w_err;
                r_idx   <= w_idx;
                r_wdata <= pwdata;
            end
        end
    end

    assign w_ready = (r_state == ACCESS) && psel && penable && (r_wcnt == 4'd0);
    assign w_we    = w_ready && r_write && !r_err;

    apb_regbank #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regbank (
        .pclk     (pclk),
        .preset_n (preset_n),
        .i_we     (w_we),
        .i_widx   (r_idx),
        .i_wdata  (r_wdata),
        .i_ridx   (r_idx),
        .o_rdata  (w_rdata)
    );

    assign pready  = w_ready;
    assign pslverr = w_ready && r_err;
    assign prdata  = (w_ready && !r_err) ? w_rdata : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
// Three completers with WAIT_CYCLES 0, 1 and 3, each on its own bus. A
// behavioural model (per-transfer penable counting + word array) predicts
// pready/prdata/pslverr every cycle; directed transfers pin literal values,
// then randomized transfers exercise the rest.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

    localparam int N = 3;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        psel    [N];
    logic        penable [N];
    logic        pwrite  [N];
    logic [31:0] paddr   [N];
    logic [31:0] pwdata  [N];
    logic [31:0] prdata  [N];
    logic        pready  [N];
    logic        pslverr [N];

    always #5 pclk = ~pclk;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            apb_slave_mem #(
                .ADDR_WIDTH  (32),
                .DATA_WIDTH  (32),
                .DEPTH       (64),
                .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 1 : 3),
                .BASE_ADDR   (32'h0000_0000)
            ) u_dut (
                .pclk     (pclk),
                .preset_n (preset_n),
                .psel     (psel[g]),
                .penable  (penable[g]),
                .pwrite   (pwrite[g]),
                .paddr    (paddr[g]),
                .pwdata   (pwdata[g]),
                .prdata   (prdata[g]),
                .pready   (pready[g]),
                .pslverr  (pslverr[g])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;

    function automatic int wc(input int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mmem  [N][64];
    bit          m_act [N];
    int          m_pen [N];   // penable cycles seen in the current transfer
    bit          m_wr  [N];
    bit          m_err [N];
    int          m_idx [N];
    logic [31:0] m_wd  [N];

    always @(negedge pclk) begin : p_cmp
        bit          er, ee;
        logic [31:0] ed, off;
        for (int k = 0; k < N; k++) begin
            if (!preset_n) begin
                er = 0; ee = 0; ed = '0;
                m_act[k] = 0;
                for (int i = 0; i < 64; i++) mmem[k][i] = '0;
            end else begin
                // Response lands on the (WAIT_CYCLES+1)th penable cycle.
                er = m_act[k] && psel[k] && penable[k] && (m_pen[k] == wc(k));
                ee = er && m_err[k];
                ed = (er && !m_err[k]) ? mmem[k][m_idx[k]] : 32'h0;
            end
            chk($sformatf("pready[%0d]", k),  32'(pready[k]),  32'(er));
            chk($sformatf("pslverr[%0d]", k), 32'(pslverr[k]), 32'(ee));
            chk($sformatf("prdata[%0d]", k),  prdata[k],       ed);
            if (preset_n) begin
                if (m_act[k]) begin
                    if (!psel[k]) begin
                        m_act[k] = 0;
                    end else if (penable[k]) begin
                        if (m_pen[k] == wc(k)) begin
                            m_act[k] = 0;
                            if (m_wr[k] && !m_err[k]) mmem[k][m_idx[k]] = m_wd[k];
                        end else begin
                            m_pen[k]++;
                        end
                    end
                end else if (psel[k] && !penable[k]) begin
                    off      = paddr[k] - 32'h0;
                    m_act[k] = 1;
                    m_pen[k] = 0;
                    m_wr[k]  = pwrite[k];
                    m_wd[k]  = pwdata[k];
                    m_err[k] = (paddr[k][1:0] != 2'b00) || (off >= 32'd256);
                    m_idx[k] = int'((off >> 2) & 32'd63);
                end
            end
        end
    end

    // ---------------- requester ----------------
    // Called at 1 time unit after a rising edge; returns at the same point.
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input int hold, input int abort_n,
                        input bit mut, output logic [31:0] rd, output bit er,
                        output int lat, output bit done);
        psel[k] = 1; penable[k] = 0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = data;
        for (int h = 0; h <= hold; h++) begin
            @(posedge pclk); #1;
        end
        penable[k] = 1;
        lat = 0; done = 0; rd = '0; er = 0;
        while (!done && lat < 40) begin
            lat++;
            @(negedge pclk);
            if (pready[k]) begin
                done = 1; rd = prdata[k]; er = pslverr[k];
            end
            @(posedge pclk); #1;
            if (!done) begin
                if (mut) begin
                    paddr[k] = addr ^ 32'h0000_0030; pwdata[k] = ~data;
                end
                if (abort_n != 0 && lat == abort_n) break;
            end
        end
        psel[k] = 0; penable[k] = 0;
        if (!done && abort_n == 0) begin
            checks++; errors++;
            $display("FAIL timeout[%0d]: no pready after %0d cycles, expected one", k, lat);
        end
    endtask

    task automatic do_rd(input int k, input logic [31:0] addr, output logic [31:0] rd,
                         output bit er, output int lat);
        bit d;
        xfer(k, 0, addr, 32'h0, 0, 0, 0, rd, er, lat, d);
    endtask

    task automatic do_wr(input int k, input logic [31:0] addr, input logic [31:0] data,
                         output bit er, output int lat);
        logic [31:0] rd;
        bit d;
        xfer(k, 1, addr, data, 0, 0, 0, rd, er, lat, d);
    endtask

    initial begin : p_main
        logic [31:0] rd, a;
        bit          er, done;
        int          lat, k;

        for (int i = 0; i < N; i++) begin
            psel[i] = 0; penable[i] = 0; pwrite[i] = 0; paddr[i] = '0; pwdata[i] = '0;
        end
        preset_n = 0;
        repeat (3) @(posedge pclk);
        #1 preset_n = 1;

        // WAIT_CYCLES=1: write then read 0x08
        do_wr(1, 32'h08, 32'hDEAD_BEEF, er, lat);
        chk("w1_wr_lat", 32'(lat), 32'd2);
        chk("w1_wr_err", 32'(er), 32'd0);
        do_rd(1, 32'h08, rd, er, lat);
        chk("w1_rd_lat", 32'(lat), 32'd2);
        chk("w1_rd_data", rd, 32'hDEAD_BEEF);
        chk("w1_rd_err", 32'(er), 32'd0);

        // WAIT_CYCLES=0: back-to-back writes then reads, no idle between
        do_wr(0, 32'h00, 32'h1111_1111, er, lat);
        chk("w0_wr0_lat", 32'(lat), 32'd1);
        do_wr(0, 32'h04, 32'h2222_2222, er, lat);
        chk("w0_wr1_lat", 32'(lat), 32'd1);
        do_rd(0, 32'h00, rd, er, lat);
        chk("w0_rd0_data", rd, 32'h1111_1111);
        chk("w0_rd0_lat", 32'(lat), 32'd1);
        do_rd(0, 32'h04, rd, er, lat);
        chk("w0_rd1_data", rd, 32'h2222_2222);

        // Error responses: misaligned read, out-of-range write (index 64)
        do_rd(0, 32'h0000_0102, rd, er, lat);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_data", rd, 32'h0);
        do_wr(0, 32'h0000_0100, 32'hFFFF_FFFF, er, lat);
        chk("oor_err", 32'(er), 32'd1);
        do_rd(0, 32'h00, rd, er, lat);
        chk("oor_keep", rd, 32'h1111_1111);

        // WAIT_CYCLES=3: abort after 2 access cycles
        xfer(2, 1, 32'h10, 32'hCAFE_0010, 0, 2, 0, rd, er, lat, done);
        chk("abort_done", 32'(done), 32'd0);
        @(posedge pclk); #1;
        do_rd(2, 32'h10, rd, er, lat);
        chk("abort_rd", rd, 32'h0);
        chk("w3_rd_lat", 32'(lat), 32'd4);

        // Address/data change during wait states is ignored
        xfer(2, 1, 32'h14, 32'hA5A5_0014, 0, 0, 1, rd, er, lat, done);
        do_rd(2, 32'h14, rd, er, lat);
        chk("mut_keep", rd, 32'hA5A5_0014);
        do_rd(2, 32'h24, rd, er, lat);
        chk("mut_other", rd, 32'h0);

        // psel+penable without a setup phase gets no response
        psel[1] = 1; penable[1] = 1; pwrite[1] = 0; paddr[1] = 32'h08;
        repeat (2) begin
            @(negedge pclk);
            chk("no_setup_rdy", 32'(pready[1]), 32'd0);
            @(posedge pclk); #1;
        end
        psel[1] = 0; penable[1] = 0;

        // Reset in the middle of a write
        do_wr(2, 32'h0C, 32'h5, er, lat);
        do_rd(2, 32'h0C, rd, er, lat);
        chk("pre_rst_rd", rd, 32'h5);
        psel[2] = 1; penable[2] = 0; pwrite[2] = 1; paddr[2] = 32'h0C; pwdata[2] = 32'h77;
        @(posedge pclk); #1 penable[2] = 1;
        @(posedge pclk); #1 preset_n = 0;
        #1 chk("rst_rdy", 32'(pready[2]), 32'd0);
        psel[2] = 0; penable[2] = 0;
        @(posedge pclk); @(posedge pclk); #1 preset_n = 1;
        do_rd(2, 32'h0C, rd, er, lat);
        chk("post_rst_rd", rd, 32'h0);
        do_rd(0, 32'h00, rd, er, lat);
        chk("post_rst_rd0", rd, 32'h0);

        // Randomized traffic; the compare process checks every cycle
        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(0, N - 1));
            case ($urandom_range(0, 9))
                0:       a = ($urandom_range(0, 63) << 2) | $urandom_range(1, 3);
                1:       a = 32'h100 + ($urandom_range(0, 255) << 2);
                2:       a = 32'hFFFF_FFFC;
                default: a = $urandom_range(0, 63) << 2;
            endcase
            xfer(k, 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 1 + int'($urandom_range(0, wc(k))) : 0,
                 1'($urandom_range(0, 7) == 0), rd, er, lat, done);
            repeat ($urandom_range(0, 2)) begin
                @(posedge pclk); #1;
            end
        end

        repeat (2) @(posedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB completer that sits directly downstream of the team's APB master. It responds to the master's psel/penable/paddr/pwrite/pwdata transfers, and is used both as the bench target and as an on-chip scratch register bank. It is a word-addressed register memory with a fixed number of inserted wait states. It flags misaligned and out-of-range accesses with pslverr.

Parameters:
ADDR_WIDTH, 32, width of paddr
DATA_WIDTH, 32, width of pwdata/prdata; fixed at 32 for byte-offset decode
DEPTH, 64, number of 32-bit words; power of two, 2..1024
WAIT_CYCLES, 1, wait states inserted before pready; 0..15
BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH*4-aligned

Ports:
pclk  in  1  APB clock
preset_n  in  1  async active-low reset
psel  in  1  slave select
penable  in  1  access phase strobe
pwrite  in  1  1=write, 0=read
paddr  in  ADDR_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data
prdata  out  DATA_WIDTH  read data, valid only while pready=1
pready  out  1  transfer complete
pslverr  out  1  error response, valid only while pready=1

Behaviour:
- Reset: pclk is the clock. preset_n is an asynchronous, active-low reset. Reset drives state=IDLE, wait counter=0, all DEPTH words=0, prdata=0, pready=0, pslverr=0.
- State machine (registered state):
  - IDLE -> SETUP when psel=1 and penable=0. In the same cycle, latch paddr/pwrite/pwdata, load wcnt=WAIT_CYCLES, and compute err.
  - SETUP -> ACCESS on the next cycle.
  - ACCESS: while psel=1 and penable=1 and wcnt!=0, decrement wcnt.
  - Completion cycle: psel=1, penable=1, wcnt==0.
  - After completion: -> IDLE, or -> SETUP if psel=1 and penable=0 on the following cycle (back-to-back transfers).
- The master may hold penable=0 for one or more cycles after SETUP. The slave stays in ACCESS without decrementing until penable=1.
- Outputs:
  - pready = (state==ACCESS) & psel & penable & (wcnt==0). This is combinational from registered state.
  - pready is 0 outside the access phase, including while penable=0.
  - prdata and pslverr are driven from latched values and gated to 0 when pready=0.
- Latency: WAIT_CYCLES+1 cycles from the first cycle with penable=1 to pready=1, inclusive. WAIT_CYCLES=0 gives pready in the first penable cycle.
- Error (err) conditions:
  - paddr[1:0]!=0 (misaligned).
  - (paddr-BASE_ADDR) >= DEPTH*4 (out of range). The subtraction is unsigned; addresses below BASE_ADDR wrap and are therefore out of range.
- Error response: pslverr=1 and prdata=0 in the completion cycle. No memory update occurs.
- Write: the word at index (paddr-BASE_ADDR)>>2 is updated at the clock edge ending the completion cycle, only if pwrite=1 and err=0. A read in the next transfer returns the new value.
- Read: prdata = mem[index] sampled in the completion cycle.
- Abort: if psel falls before completion, go to IDLE, perform no write, and keep pready=0.
- Protocol errors:
  - paddr, pwrite or pwdata changing during ACCESS is ignored; the latched values are used.
  - psel=1 with penable=1 seen in IDLE is ignored; no response is given until a proper SETUP.
- Reset mid-transfer: immediate return to IDLE. The pending write is discarded; previously written memory is cleared.

Decomposition:
- Package apb_pkg holds:
  - enum apb_slv_state_t {IDLE, SETUP, ACCESS} as 2-bit.
  - constants APB_ADDR_W=32 and APB_DATA_W=32.
  - function apb_addr_err(addr, base, depth), returning the misaligned/out-of-range flag.
- One sub-module, apb_regbank: DEPTH x DATA_WIDTH flop array with async clear, one write port (we, widx, wdata), and one combinational read port (ridx -> rdata).
- The FSM, wait counter and decode stay in apb_slave_mem.

Test Plan:
- WAIT_CYCLES=1: write addr 0x08 data 0xDEAD_BEEF, then read 0x08 -> pready high 2 cycles after penable rises; read returns 0xDEAD_BEEF with pslverr=0; master reports done=1, error=0.
- WAIT_CYCLES=0: back-to-back writes to 0x00 and 0x04 (0x1111_1111, 0x2222_2222), then reads -> each pready in the first penable cycle; reads return the written values; no idle cycle is required between transfers.
- Read 0x0000_0102 (misaligned) and write 0x0000_0100 (index 64, DEPTH=64) -> pslverr=1, prdata=0; a subsequent read of 0x00 is unchanged.
- WAIT_CYCLES=3: start a write to 0x10 and drop psel after 2 access cycles -> pready stays 0 and the FSM returns to IDLE; a read of 0x10 returns 0.
- Assert preset_n=0 mid-access of a write to 0x0C after earlier writing 0x0C=0x5 -> pready=0 immediately; after reset release, a read of 0x0C returns 0.
- Change paddr and pwdata during the wait states of a write to 0x14 -> 0x14 holds the data latched at setup; the new address is untouched.
